servo_track_sched: RTL and testbench
====================================

# servo_track_sched

Sequencing controller for the pan/tilt servo path. Accepts target pixel offsets from the vision pipeline over a valid/ready handshake, converts them to servo position targets with a multi-cycle sequential divider, and commits slew-limited pan/tilt commands once per servo frame. Returns the servos to centre when no target has arrived for a configurable number of frames. Sits between the object-detection output and the PWM generators.

## Interface

**Parameters**

- `FRAME_CYCLES`, default 1000000: clock cycles per servo frame (20 ms at 50 MHz); must be ≥ 64.
- `PAN_CENTER`, default 611: pan home position.
- `TILT_CENTER`, default 611: tilt home position.
- `MIN_POS`, default 400: lower clamp for pan and tilt.
- `MAX_POS`, default 822: upper clamp for pan and tilt.
- `MAX_STEP`, default 4: maximum per-frame position change, when slew limiting is enabled.
- `TIMEOUT_FRAMES`, default 50: number of frames without a target before the servos return home.

**Ports**

- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-high.
- `tgt_valid` in 1: target offset valid.
- `tgt_x` in 10: signed pixel offset from image centre, x.
- `tgt_y` in 9: signed pixel offset from image centre, y.
- `tgt_ready` out 1: block can accept a target.
- `pan` out 11: committed pan command.
- `tilt` out 11: committed tilt command.
- `cmd_valid` out 1: one-cycle pulse when `pan`/`tilt` are committed.
- `tracking` out 1: target seen within the timeout window.

## Operation

**State machine:** IDLE → DIV_X → DIV_Y → LATCH → IDLE.
- IDLE: `tgt_ready`=1. On `tgt_valid & tgt_ready`:
  - capture `tgt_x` and `tgt_y`;
  - clear the frame-miss counter;
  - go to DIV_X.
- DIV_X: 16 cycles. Restoring divide of `|x|·64` (16-bit unsigned) by 180, one quotient bit per cycle, MSB first.
- DIV_Y: 16 cycles. Same operation on `|y|·64`.
- LATCH: 1 cycle. Apply sign to each quotient (truncation toward zero), giving `x_off` and `y_off`.
  - `pan_tgt = clamp(PAN_CENTER − x_off)`.
  - `tilt_tgt = clamp(TILT_CENTER − y_off)`.
  - Clamp is to [MIN_POS, MAX_POS]. Intermediates are 12-bit signed, so there is no wrap.
- `tgt_ready`=0 in every state except IDLE. `tgt_valid` is ignored outside IDLE; no queuing.

**Frame tick**
- A free-running counter counts 0..FRAME_CYCLES−1. The tick is asserted when the counter = FRAME_CYCLES−1.
- On a tick:
  - step `pan` toward `pan_tgt` and `tilt` toward `tilt_tgt`;
  - pulse `cmd_valid` (it pulses every tick, even with no change);
  - increment the miss counter, saturating at TIMEOUT_FRAMES.
- When the miss counter reaches TIMEOUT_FRAMES:
  - `pan_tgt` and `tilt_tgt` are forced to the centre values;
  - `tracking`=0.
- `tracking` returns to 1 on the next accepted target.

**Simultaneous events**
- Tick in the same cycle as LATCH: the tick uses the targets registered before that edge. The new targets apply from the next tick.
- Tick in the same cycle as acceptance: the miss counter clears; the clear wins over the increment.

**Reset (any cycle, including mid-division)**
- Abort the division. Go to IDLE.
- `pan`=`pan_tgt`=PAN_CENTER; `tilt`=`tilt_tgt`=TILT_CENTER.
- `cmd_valid`=0, `tracking`=0, `tgt_ready`=0.
- Frame and miss counters = 0.

## Timing

- Acceptance edge = cycle 0.
- DIV_X runs in cycles 1–16, DIV_Y in cycles 17–32, LATCH in cycle 33.
- `pan_tgt`/`tilt_tgt` are valid after the edge ending cycle 33.
- `tgt_ready` reasserts in cycle 34. Minimum target period is 34 cycles.
- `pan`/`tilt` change only on frame-tick edges; `cmd_valid` is high for exactly that cycle.
- `tgt_ready` is 1 from the first cycle after `rst` deasserts.

## Configuration

- Macro `SERVO_SLEW_LIMIT_EN`.
- Defined: each tick moves each axis by `min(|tgt − cur|, MAX_STEP)` toward its target.
- Undefined: each tick copies the target directly (`pan ← pan_tgt`, `tilt ← tilt_tgt`). `MAX_STEP` is unused.

## Test plan

Bench parameters: `FRAME_CYCLES`=100, `TIMEOUT_FRAMES`=5, other parameters at default.

1. Reset → `pan`=611, `tilt`=611, `tracking`=0, `cmd_valid`=0. `tgt_ready`=1 one cycle after release.
2. `tgt_x`=180, `tgt_y`=90, slew disabled:
   - `pan_tgt`=547, `tilt_tgt`=579 at cycle 34;
   - next tick → `pan`=547, `tilt`=579.
3. `tgt_x`=−512, `tgt_y`=−256 → `x_off`=−182, `y_off`=−91 → `pan_tgt`=793, `tilt_tgt`=702. Then `tgt_x`=100 → `pan_tgt`=576 (35.55 truncated to 35).
4. `SERVO_SLEW_LIMIT_EN` defined, `tgt_x`=180 → `pan` steps 611, 607, 603, … and reaches 547 after 16 ticks. `MIN_POS`=600 → `pan_tgt` clamps to 600.
5. Target, then no input for 5 ticks:
   - `tracking` falls on the 5th tick;
   - axes return to 611;
   - a new target restores `tracking`=1.
6. Hold `tgt_valid` high continuously → accepts spaced exactly 34 cycles apart. `rst` pulsed at cycle 10 of DIV_X → no LATCH, outputs return to centre.

Source files
------------

// File: rtl/servo_track_sched.sv
// servo_track_sched: pan/tilt sequencing controller.
//
// Accepts signed pixel offsets over a valid/ready handshake. Each offset is
// converted to a position offset (|v|*64/180) by a bit-serial restoring
// divider. The result is clamped around the centre position. One slewed
// command is committed per servo frame. With no target for TIMEOUT_FRAMES
// frames, the targets fall back to centre.
//
// Optional feature: define SERVO_SLEW_LIMIT_EN to limit each per-frame move
// to MAX_STEP. When it is undefined, each frame copies the target directly.
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   tgt_valid  in   target offset valid
//   tgt_x      in   signed pixel offset x (10 bit)
//   tgt_y      in   signed pixel offset y (9 bit)
//   tgt_ready  out  block can accept a target (idle)
//   pan        out  committed pan command (11 bit)
//   tilt       out  committed tilt command (11 bit)
//   cmd_valid  out  one-cycle pulse after each frame commit
//   tracking   out  target seen within the timeout window
module servo_track_sched #(
    parameter int unsigned FRAME_CYCLES   = 1000000,
    parameter int unsigned PAN_CENTER     = 611,
    parameter int unsigned TILT_CENTER    = 611,
    parameter int unsigned MIN_POS        = 400,
    parameter int unsigned MAX_POS        = 822,
    parameter int unsigned MAX_STEP       = 4,
    parameter int unsigned TIMEOUT_FRAMES = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tgt_valid,
    input  logic [9:0]  tgt_x,
    input  logic [8:0]  tgt_y,
    output logic        tgt_ready,
    output logic [10:0] pan,
    output logic [10:0] tilt,
    output logic        cmd_valid,
    output logic        tracking
);

    localparam int unsigned FcW   = $clog2(FRAME_CYCLES);
    localparam int unsigned MissW = (TIMEOUT_FRAMES < 1) ? 1 : $clog2(TIMEOUT_FRAMES + 1);
    localparam logic signed [11:0] MinPos  = 12'(MIN_POS);
    localparam logic signed [11:0] MaxPos  = 12'(MAX_POS);
    localparam logic signed [11:0] PanCtr  = 12'(PAN_CENTER);
    localparam logic signed [11:0] TiltCtr = 12'(TILT_CENTER);
    localparam logic [8:0]         Divisor = 9'd180;

    typedef enum logic [1:0] {StIdle, StDivX, StDivY, StLatch} state_e;

    state_e             state_q, state_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]         rem_q, rem_d;
    logic [15:0]        dvd_q, dvd_d;     // dividend in, quotient shifted in from the LSB
    logic [7:0]         qx_q, qx_d;
    logic               sx_q, sx_d, sy_q, sy_d;
    logic [8:0]         ymag_q, ymag_d;
    logic               ready_q, ready_d;
    logic [FcW-1:0]     frame_q, frame_d;
    logic [MissW-1:0]   miss_q, miss_d;
    logic               track_q, track_d;
    logic               cmd_q, cmd_d;
    logic [10:0]        pan_q, pan_d, tilt_q, tilt_d;
    logic [10:0]        pan_tgt_q, pan_tgt_d, tilt_tgt_q, tilt_tgt_d;

    logic               tick, accept, q_bit;
    logic [8:0]         rem_sh;
    logic [7:0]         rem_nx;
    logic [9:0]         xmag;
    logic [8:0]         ymag;
    logic signed [11:0] x_off, y_off;

    function automatic logic [10:0] clamp_pos(input logic signed [11:0] v);
        if (v < MinPos) return MinPos[10:0];
        if (v > MaxPos) return MaxPos[10:0];
        return v[10:0];
    endfunction

`ifdef SERVO_SLEW_LIMIT_EN
    localparam logic signed [11:0] Step = 12'(MAX_STEP);

    function automatic logic [10:0] step_toward(input logic [10:0] cur, input logic [10:0] tgt);
        logic signed [11:0] diff;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        if (diff > Step) return 11'($signed({1'b0, cur}) + Step);
        if (diff < -Step) return 11'($signed({1'b0, cur}) - Step);
        return tgt;
    endfunction
`else
    logic unused_max_step;
    assign unused_max_step = (MAX_STEP != 0);
`endif

    assign tgt_ready = ready_q;
    assign pan       = pan_q;
    assign tilt      = tilt_q;
    assign cmd_valid = cmd_q;
    assign tracking  = track_q;

    always_comb begin
        tick   = (frame_q == FcW'(FRAME_CYCLES - 1));
        accept = tgt_valid & ready_q;
        xmag   = tgt_x[9] ? (~tgt_x + 10'd1) : tgt_x;
        ymag   = tgt_y[8] ? (~tgt_y + 9'd1) : tgt_y;

        // One restoring-division step: remainder stays below 180, so 8 bits hold it.
        rem_sh = {rem_q, dvd_q[15]};
        q_bit  = (rem_sh >= Divisor);
        rem_nx = q_bit ? 8'(rem_sh - Divisor) : rem_sh[7:0];

        x_off = sx_q ? -$signed({4'b0, qx_q}) : $signed({4'b0, qx_q});
        y_off = sy_q ? -$signed({4'b0, dvd_q[7:0]}) : $signed({4'b0, dvd_q[7:0]});

        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rem_d      = rem_q;
        dvd_d      = dvd_q;
        qx_d       = qx_q;
        sx_d       = sx_q;
        sy_d       = sy_q;
        ymag_d     = ymag_q;
        pan_tgt_d  = pan_tgt_q;
        tilt_tgt_d = tilt_tgt_q;

        // Timed-out: hold targets at centre until a new target is latched.
        if (miss_q == MissW'(TIMEOUT_FRAMES)) begin
            pan_tgt_d  = PanCtr[10:0];
            tilt_tgt_d = TiltCtr[10:0];
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d   = StDivX;
                    sx_d      = tgt_x[9];
                    sy_d      = tgt_y[8];
                    ymag_d    = ymag;
                    dvd_d     = {xmag, 6'b0};
                    rem_d     = '0;
                    bit_cnt_d = '0;
                end
            end
            StDivX: begin
                rem_d     = rem_nx;
                dvd_d     = {dvd_q[14:0], q_bit};
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd15) begin
                    qx_d    = {dvd_q[6:0], q_bit};
                    dvd_d   = {1'b0, ymag_q, 6'b0};
                    rem_d   = '0;
                    state_d = StDivY;
                end
            end
            StDivY: begin
                rem_d     = rem_nx;
                dvd_d     = {dvd_q[14:0], q_bit};
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd15) state_d = StLatch;
            end
            StLatch: begin
                pan_tgt_d  = clamp_pos(PanCtr - x_off);
                tilt_tgt_d = clamp_pos(TiltCtr - y_off);
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase

        ready_d = (state_d == StIdle);
        frame_d = tick ? '0 : frame_q + 1'b1;
        cmd_d   = tick;

        // Acceptance clears the miss count, even on a tick.
        miss_d  = miss_q;
        track_d = track_q;
        if (accept) begin
            miss_d  = '0;
            track_d = 1'b1;
        end else if (tick) begin
            if (miss_q != MissW'(TIMEOUT_FRAMES)) miss_d = miss_q + 1'b1;
            if (miss_d == MissW'(TIMEOUT_FRAMES)) track_d = 1'b0;
        end

        pan_d  = pan_q;
        tilt_d = tilt_q;
        if (tick) begin
`ifdef SERVO_SLEW_LIMIT_EN
            pan_d  = step_toward(pan_q, pan_tgt_q);
            tilt_d = step_toward(tilt_q, tilt_tgt_q);
`else
            pan_d  = pan_tgt_q;
            tilt_d = tilt_tgt_q;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            rem_q      <= '0;
            dvd_q      <= '0;
            qx_q       <= '0;
            sx_q       <= 1'b0;
            sy_q       <= 1'b0;
            ymag_q     <= '0;
            ready_q    <= 1'b0;
            frame_q    <= '0;
            miss_q     <= '0;
            track_q    <= 1'b0;
            cmd_q      <= 1'b0;
            pan_q      <= PanCtr[10:0];
            tilt_q     <= TiltCtr[10:0];
            pan_tgt_q  <= PanCtr[10:0];
            tilt_tgt_q <= TiltCtr[10:0];
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rem_q      <= rem_d;
            dvd_q      <= dvd_d;
            qx_q       <= qx_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            ymag_q     <= ymag_d;
            ready_q    <= ready_d;
            frame_q    <= frame_d;
            miss_q     <= miss_d;
            track_q    <= track_d;
            cmd_q      <= cmd_d;
            pan_q      <= pan_d;
            tilt_q     <= tilt_d;
            pan_tgt_q  <= pan_tgt_d;
            tilt_tgt_q <= tilt_tgt_d;
        end
    end

endmodule

// File: tb/tb_servo_track_sched.sv
// Bench for servo_track_sched. Two instances share the stimulus: one with
// default clamps, one with a narrow clamp window [600, 620]. A behavioural
// model tracks the busy window, frame ticks, miss count and positions.
module tb_servo_track_sched;
    localparam int FRAME = 100;
    localparam int TO    = 5;
    localparam int LO[2] = '{400, 600};
    localparam int HI[2] = '{822, 620};

    logic        clk = 1'b0;
    logic        rst, tgt_valid;
    logic [9:0]  tgt_x;
    logic [8:0]  tgt_y;
    logic        rdy0, cv0, tr0, rdy1, cv1, tr1;
    logic [10:0] pan0, tilt0, pan1, tilt1;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;
    bit spacing_on = 0;

    always #5 clk = ~clk;

    servo_track_sched #(.FRAME_CYCLES(FRAME), .TIMEOUT_FRAMES(TO)) u_dut (
        .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_x(tgt_x), .tgt_y(tgt_y),
        .tgt_ready(rdy0), .pan(pan0), .tilt(tilt0), .cmd_valid(cv0), .tracking(tr0)
    );

    servo_track_sched #(.FRAME_CYCLES(FRAME), .TIMEOUT_FRAMES(TO), .MIN_POS(600),
                        .MAX_POS(620)) u_clamp (
        .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_x(tgt_x), .tgt_y(tgt_y),
        .tgt_ready(rdy1), .pan(pan1), .tilt(tilt1), .cmd_valid(cv1), .tracking(tr1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_fc, m_miss, m_busy, m_x, m_y;
    bit m_ready, m_track, m_cmd, m_acc;
    int m_pan[2], m_tilt[2], m_pt[2], m_tt[2];

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic int step(input int cur, input int tgt);
`ifdef SERVO_SLEW_LIMIT_EN
        if (tgt > cur) return cur + ((tgt - cur > 4) ? 4 : tgt - cur);
        return cur - ((cur - tgt > 4) ? 4 : cur - tgt);
`else
        return tgt + 0 * cur;
`endif
    endfunction

    always @(posedge clk) begin
        bit tick;
        m_acc = 0;
        if (rst) begin
            m_fc = 0; m_miss = 0; m_busy = 0; m_ready = 0; m_track = 0; m_cmd = 0;
            for (int i = 0; i < 2; i++) begin
                m_pan[i] = 611; m_tilt[i] = 611; m_pt[i] = 611; m_tt[i] = 611;
            end
        end else begin
            tick  = (m_fc == FRAME - 1);
            m_fc  = tick ? 0 : m_fc + 1;
            m_cmd = tick;
            if (tick) begin
                for (int i = 0; i < 2; i++) begin
                    m_pan[i]  = step(m_pan[i], m_pt[i]);
                    m_tilt[i] = step(m_tilt[i], m_tt[i]);
                end
            end
            if (m_ready && tgt_valid) begin
                m_acc = 1; m_x = int'($signed(tgt_x)); m_y = int'($signed(tgt_y));
                m_busy = 33; m_miss = 0; m_track = 1;
            end else begin
                if (tick && m_miss < TO) m_miss++;
                if (tick && m_miss == TO) begin
                    m_track = 0;
                    for (int i = 0; i < 2; i++) begin m_pt[i] = 611; m_tt[i] = 611; end
                end
                if (m_busy > 0) begin
                    m_busy--;
                    if (m_busy == 0) begin
                        for (int i = 0; i < 2; i++) begin
                            m_pt[i] = clampi(611 - (m_x * 64) / 180, LO[i], HI[i]);
                            m_tt[i] = clampi(611 - (m_y * 64) / 180, LO[i], HI[i]);
                        end
                    end
                end
            end
            m_ready = (m_busy == 0);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_eq("pan0", 32'(pan0), m_pan[0]);
            check_eq("tilt0", 32'(tilt0), m_tilt[0]);
            check_eq("pan1", 32'(pan1), m_pan[1]);
            check_eq("tilt1", 32'(tilt1), m_tilt[1]);
            check_eq("ready0", 32'(rdy0), 32'(m_ready));
            check_eq("ready1", 32'(rdy1), 32'(m_ready));
            check_eq("cmd0", 32'(cv0), 32'(m_cmd));
            check_eq("cmd1", 32'(cv1), 32'(m_cmd));
            check_eq("track0", 32'(tr0), 32'(m_track));
            check_eq("track1", 32'(tr1), 32'(m_track));
        end
    end

    // Accepts under continuously held valid must be exactly 34 cycles apart.
    int cyc = 0;
    int last_acc = -1;
    always @(posedge clk) begin
        cyc++;
        if (rst || !spacing_on) last_acc = -1;
        else if (tgt_valid && rdy0) begin
            if (last_acc >= 0) check_eq("accept_spacing", 32'(cyc - last_acc), 34);
            last_acc = cyc;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input int x, input int y);
        int k = 0;
        @(negedge clk);
        tgt_valid = 1; tgt_x = 10'(x); tgt_y = 9'(y);
        do begin @(posedge clk); #1; k++; end while (!m_acc && k < 200);
        check_eq("accept_timeout", 32'(k < 200), 1);
        @(negedge clk);
        tgt_valid = 0;
    endtask

    // Wait for the latch, then for the first tick that uses the new targets.
    task automatic wait_cmd();
        int k = 0;
        do begin @(posedge clk); #1; k++; end while (!m_ready && k < 100);
        do begin @(posedge clk); #1; k++; end while (!m_cmd && k < 400);
        check_eq("cmd_timeout", 32'(k < 400), 1);
        @(negedge clk);
    endtask

    task automatic wait_ticks(input int n);
        int k = 0;
        for (int t = 0; t < n; t++) begin
            do begin @(posedge clk); #1; k++; end while (!m_cmd && k < 2000);
        end
        check_eq("tick_timeout", 32'(k < 2000), 1);
        @(negedge clk);
    endtask

    initial begin
        rst = 1; tgt_valid = 0; tgt_x = '0; tgt_y = '0;
        @(negedge clk);
        chk_en = 1;
        repeat (2) @(negedge clk);
        check_eq("rst_pan", 32'(pan0), 611);
        check_eq("rst_tilt", 32'(tilt0), 611);
        check_eq("rst_track", 32'(tr0), 0);
        check_eq("rst_cmd", 32'(cv0), 0);
        check_eq("rst_ready", 32'(rdy0), 0);
        rst = 0;
        @(negedge clk);
        check_eq("ready_after_rst", 32'(rdy0), 1);

        send(180, 90);
        wait_cmd();
`ifdef SERVO_SLEW_LIMIT_EN
        check_eq("t2_pan", 32'(pan0), 607);
        check_eq("t2_clamp_pan", 32'(pan1), 607);
`else
        check_eq("t2_pan", 32'(pan0), 547);
        check_eq("t2_tilt", 32'(tilt0), 579);
        check_eq("t2_clamp_pan", 32'(pan1), 600);
        check_eq("t2_clamp_tilt", 32'(tilt1), 600);
`endif

        send(-512, -256);
        wait_cmd();
`ifndef SERVO_SLEW_LIMIT_EN
        check_eq("t3_pan", 32'(pan0), 793);
        check_eq("t3_tilt", 32'(tilt0), 702);
        check_eq("t3_clamp_pan", 32'(pan1), 620);
`endif
        send(100, 0);
        wait_cmd();
`ifndef SERVO_SLEW_LIMIT_EN
        check_eq("t3_trunc_pan", 32'(pan0), 576);
        check_eq("t3_tilt_ctr", 32'(tilt0), 611);
`endif
        check_eq("track_on", 32'(tr0), 1);

        wait_ticks(6);
        check_eq("timeout_track", 32'(tr0), 0);
`ifndef SERVO_SLEW_LIMIT_EN
        check_eq("timeout_pan", 32'(pan0), 611);
        check_eq("timeout_tilt", 32'(tilt0), 611);
`endif
        send(-30, 20);
        check_eq("track_restored", 32'(tr0), 1);

        // Continuously held valid with changing offsets.
        spacing_on = 1;
        @(negedge clk);
        tgt_valid = 1;
        repeat (250) begin
            @(negedge clk);
            tgt_x = 10'($urandom); tgt_y = 9'($urandom);
        end
        spacing_on = 0;
        tgt_valid = 0;
        repeat (40) @(negedge clk);

        // Reset during DIV_X: no latch, outputs back to centre.
        send(200, -100);
        repeat (9) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check_eq("midrst_pan", 32'(pan0), 611);
        check_eq("midrst_tilt", 32'(tilt0), 611);
        check_eq("midrst_ready", 32'(rdy0), 0);
        check_eq("midrst_track", 32'(tr0), 0);
        repeat (150) @(negedge clk);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 999) == 0);
            tgt_valid = ($urandom_range(0, 15) == 0);
            tgt_x     = 10'($urandom);
            tgt_y     = 9'($urandom);
        end
        @(negedge clk);
        rst = 0; tgt_valid = 0;
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
